// File: rtl/gf_poly_mult_seq_if.sv
// gf_poly_mult_seq_if: load/done handshake and operand/result bus of the GF multiplier.
interface gf_poly_mult_seq_if #(parameter int WIDTH = 8);
  logic             load;
  logic [WIDTH-1:0] mpr_in;
  logic [WIDTH-1:0] mcd_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  modport master (output load, mpr_in, mcd_in, input busy, done, result);
  modport slave  (input load, mpr_in, mcd_in, output busy, done, result);
endinterface

// File: rtl/gf_poly_mult_seq.sv
// gf_poly_mult_seq: sequential GF(2^WIDTH) shift-and-add multiplier with per-step reduction.
module gf_poly_mult_seq #(
  parameter int             WIDTH      = 8,
  parameter logic [WIDTH:0] POLY       = 9'h11B,
  parameter bit             EARLY_TERM = 1'b1
) (
  input logic              clk,
  input logic              nrst,
  gf_poly_mult_seq_if.slave bus
);
  localparam int               CW  = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] RED = POLY[WIDTH-1:0];
  typedef enum logic [2:0] {IDLE = 3'b001, RUN = 3'b010, DONE = 3'b100} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] mpr_q, mpr_d, mcd_q, mcd_d, acc_q, acc_d, result_q, result_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             term;
  assign term = EARLY_TERM ? (mcd_q == '0) : (cnt_q == CW'(WIDTH));
  always_comb begin
    state_d  = state_q;
    mpr_d    = mpr_q;
    mcd_d    = mcd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = bus.load ? RUN : IDLE;
        if (bus.load) begin
          mpr_d = bus.mpr_in;
          mcd_d = bus.mcd_in;
          acc_d = '0;
          cnt_d = '0;
        end
      end
      RUN: begin
        if (term) begin
          result_d = acc_q;
          state_d  = DONE;
        end else begin
          // multiply mpr by x and fold the overflow back through the field polynomial
          acc_d = mcd_q[0] ? acc_q ^ mpr_q : acc_q;
          mpr_d = {mpr_q[WIDTH-2:0], 1'b0} ^ (mpr_q[WIDTH-1] ? RED : '0);
          mcd_d = mcd_q >> 1;
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      mpr_q    <= '0;
      mcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mpr_q    <= mpr_d;
      mcd_q    <= mcd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end
  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_gf_poly_mult_seq.sv
// tb_gf_poly_mult_seq: directed checks of GF(2^8), GF(2^4) and constant-time multiplier variants.
module tb_gf_poly_mult_seq;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   passed = 0;
  int   total = 0;
  always #5 clk = ~clk;
  gf_poly_mult_seq_if #(.WIDTH(8)) if8 ();
  gf_poly_mult_seq_if #(.WIDTH(4)) if4 ();
  gf_poly_mult_seq_if #(.WIDTH(8)) ifc ();
  gf_poly_mult_seq #(.WIDTH(8), .POLY(9'h11B), .EARLY_TERM(1'b1)) u8 (.clk(clk), .nrst(nrst), .bus(if8));
  gf_poly_mult_seq #(.WIDTH(4), .POLY(5'h13), .EARLY_TERM(1'b1)) u4 (.clk(clk), .nrst(nrst), .bus(if4));
  gf_poly_mult_seq #(.WIDTH(8), .POLY(9'h11B), .EARLY_TERM(1'b0)) uc (.clk(clk), .nrst(nrst), .bus(ifc));

  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat, output logic [7:0] r);
    @(negedge clk);
    if8.load = 1'b1; if8.mpr_in = a; if8.mcd_in = b;
    @(posedge clk); #1;
    if8.load = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (if8.done) break;
    end
    r = if8.result;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, output int lat, output logic [3:0] r);
    @(negedge clk);
    if4.load = 1'b1; if4.mpr_in = a; if4.mcd_in = b;
    @(posedge clk); #1;
    if4.load = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (if4.done) break;
    end
    r = if4.result;
  endtask

  task automatic opc(input logic [7:0] a, input logic [7:0] b, output int lat, output logic [7:0] r);
    @(negedge clk);
    ifc.load = 1'b1; ifc.mpr_in = a; ifc.mcd_in = b;
    @(posedge clk); #1;
    ifc.load = 1'b0;
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (ifc.done) break;
    end
    r = ifc.result;
  endtask

  task automatic test_reset();
    if8.load = 1'b0; if8.mpr_in = '0; if8.mcd_in = '0;
    if4.load = 1'b0; if4.mpr_in = '0; if4.mcd_in = '0;
    ifc.load = 1'b0; ifc.mpr_in = '0; ifc.mcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({if8.busy, if8.done, if8.result} !== 10'h0) $display("FAIL reset8 got %h required 000", {if8.busy, if8.done, if8.result});
    else passed++;
    total++;
    if ({if4.busy, if4.done, if4.result} !== 6'h0) $display("FAIL reset4 got %h required 00", {if4.busy, if4.done, if4.result});
    else passed++;
    total++;
    if ({ifc.busy, ifc.done, ifc.result} !== 10'h0) $display("FAIL resetc got %h required 000", {ifc.busy, ifc.done, ifc.result});
    else passed++;
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_aes_early();
    int lat; logic [7:0] r;
    op8(8'h57, 8'h83, lat, r);
    total++;
    if (r !== 8'hC1) $display("FAIL aes_57x83 result got %h required c1", r); else passed++;
    total++;
    if (lat !== 9) $display("FAIL aes_57x83 latency got %0d required 9", lat); else passed++;
    total++;
    if (if8.busy !== 1'b0) $display("FAIL busy_with_done got %b required 0", if8.busy); else passed++;
  endtask

  task automatic test_fips();
    int lat; logic [7:0] r;
    op8(8'h57, 8'h13, lat, r);
    total++;
    if (r !== 8'hFE) $display("FAIL fips_57x13 result got %h required fe", r); else passed++;
    total++;
    if (lat !== 6) $display("FAIL fips_57x13 latency got %0d required 6", lat); else passed++;
    op8(8'h57, 8'h01, lat, r);
    total++;
    if (r !== 8'h57) $display("FAIL mul_57x01 result got %h required 57", r); else passed++;
    total++;
    if (lat !== 2) $display("FAIL mul_57x01 latency got %0d required 2", lat); else passed++;
    @(posedge clk); #1;
    total++;
    if ({if8.done, if8.busy, if8.result} !== 10'h057) $display("FAIL idle_hold got %h required 057", {if8.done, if8.busy, if8.result});
    else passed++;
  endtask

  task automatic test_zero();
    int lat; logic [7:0] r;
    op8(8'h57, 8'h00, lat, r);
    total++;
    if (r !== 8'h00) $display("FAIL zero_mcd result got %h required 00", r); else passed++;
    total++;
    if (lat !== 1) $display("FAIL zero_mcd latency got %0d required 1", lat); else passed++;
    @(posedge clk); #1;
    total++;
    if (if8.done !== 1'b0) $display("FAIL done_pulse_width got %b required 0", if8.done); else passed++;
  endtask

  task automatic test_gf16();
    int lat; logic [3:0] r;
    op4(4'h7, 4'h9, lat, r);
    total++;
    if (r !== 4'hA) $display("FAIL gf16_7x9 result got %h required a", r); else passed++;
    total++;
    if (lat !== 5) $display("FAIL gf16_7x9 latency got %0d required 5", lat); else passed++;
  endtask

  task automatic test_const_time();
    int lat; logic [7:0] r;
    opc(8'h57, 8'h01, lat, r);
    total++;
    if (r !== 8'h57) $display("FAIL ct_57x01 result got %h required 57", r); else passed++;
    total++;
    if (lat !== 9) $display("FAIL ct_57x01 latency got %0d required 9", lat); else passed++;
    opc(8'h57, 8'h83, lat, r);
    total++;
    if (r !== 8'hC1) $display("FAIL ct_57x83 result got %h required c1", r); else passed++;
    total++;
    if (lat !== 9) $display("FAIL ct_57x83 latency got %0d required 9", lat); else passed++;
  endtask

  task automatic test_load_in_run();
    int lat = 0;
    @(negedge clk);
    if8.load = 1'b1; if8.mpr_in = 8'h57; if8.mcd_in = 8'h83;
    @(posedge clk); #1;
    if8.load = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 2 || n == 3) begin if8.load = 1'b1; if8.mpr_in = 8'hFF; if8.mcd_in = 8'hFF; end
      else if8.load = 1'b0;
      @(posedge clk); #1;
      lat = n;
      if (if8.done) break;
    end
    if8.load = 1'b0;
    total++;
    if (if8.result !== 8'hC1) $display("FAIL load_in_run result got %h required c1", if8.result); else passed++;
    total++;
    if (lat !== 9) $display("FAIL load_in_run latency got %0d required 9", lat); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    bit seen = 1'b0;
    @(negedge clk);
    if8.load = 1'b1; if8.mpr_in = 8'h57; if8.mcd_in = 8'h83;
    @(posedge clk); #1;
    if8.load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nrst = 1'b0;
    #1;
    total++;
    if ({if8.busy, if8.done, if8.result} !== 10'h0) $display("FAIL async_reset got %h required 000", {if8.busy, if8.done, if8.result});
    else passed++;
    @(negedge clk);
    nrst = 1'b1;
    repeat (15) begin
      @(posedge clk); #1;
      if (if8.done) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL aborted_done got %b required 0", seen); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat = 0;
    @(negedge clk);
    if8.load = 1'b1; if8.mpr_in = 8'h57; if8.mcd_in = 8'h13;
    @(posedge clk); #1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (if8.done) break;
    end
    total++;
    if (if8.result !== 8'hFE || lat !== 6) $display("FAIL b2b_first got %h/%0d required fe/6", if8.result, lat); else passed++;
    if8.mpr_in = 8'h57; if8.mcd_in = 8'h01;
    @(posedge clk); #1;
    if8.load = 1'b0;
    total++;
    if ({if8.busy, if8.done} !== 2'b10) $display("FAIL b2b_restart got %b required 10", {if8.busy, if8.done}); else passed++;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      lat = n;
      if (if8.done) break;
    end
    total++;
    if (if8.result !== 8'h57 || lat !== 2) $display("FAIL b2b_second got %h/%0d required 57/2", if8.result, lat); else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_aes_early();
    test_fips();
    test_zero();
    test_gf16();
    test_const_time();
    test_load_in_run();
    test_reset_mid_op();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
